// File: rtl/bcd_updown_counter_if.sv
// Control and data bundle for bcd_updown_counter.
//   en, step, up, load, load_val : requests toward the counter
//   bcd, hex, tc, ovf            : count value, segment drive and limit flags
// master = the side issuing requests, slave = the counter itself.
interface bcd_updown_counter_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  step;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   bcd;
    logic [7*DIGITS-1:0]   hex;
    logic                  tc;
    logic                  ovf;

    modport master (
        output en, step, up, load, load_val,
        input  bcd, hex, tc, ovf
    );

    modport slave (
        input  en, step, up, load, load_val,
        output bcd, hex, tc, ovf
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with per-digit active-low seven-segment decode.
// Ports:
//   clk   - system clock, all state changes on the rising edge
//   Re_n  - asynchronous active-low reset
//   bus   - slave side of bcd_updown_counter_if:
//           en (count enable), step (count request, counted on its rising edge),
//           up (direction), load/load_val (synchronous load, priority over step),
//           bcd (count), hex (segments a..g, MSB = a), tc (terminal count),
//           ovf (one-cycle pulse when a step meets a limit)
// Parameters:
//   DIGITS - number of cascaded decades (1..8)
//   WRAP   - 1 = wrap between all-9s and all-0s, 0 = hold at the limit
module bcd_updown_counter #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                    clk,
    input  logic                    Re_n,
    bcd_updown_counter_if.slave     bus
);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    logic [4*DIGITS-1:0] bcd_reg, bcd_next;
    logic                ovf_reg, ovf_next;
    logic                step_d_reg;

    logic [DIGITS-1:0]   is_nine;
    logic [DIGITS-1:0]   is_zero;
    logic [4*DIGITS-1:0] inc_vec;
    logic [4*DIGITS-1:0] dec_vec;
    logic [4*DIGITS-1:0] load_clean;
    logic                all_nine;
    logic                all_zero;
    logic                step_edge;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            // Bits below this digit; a digit moves only when every lower digit
            // sits at its rollover value. Built as a mask so there is no ripple chain.
            localparam logic [DIGITS-1:0] LOW_MASK = (DIGITS'(1) << gi) - DIGITS'(1);

            logic [3:0] cur;
            logic [3:0] clean;
            logic [3:0] lv;
            logic       inc_here;
            logic       dec_here;

            assign cur      = bcd_reg[4*gi +: 4];
            assign lv       = bus.load_val[4*gi +: 4];
            assign clean    = (cur > 4'd9) ? 4'd0 : cur;
            assign is_nine[gi] = (cur == 4'd9);
            assign is_zero[gi] = (cur == 4'd0);
            assign inc_here = &(is_nine | ~LOW_MASK);
            assign dec_here = &(is_zero | ~LOW_MASK);

            assign inc_vec[4*gi +: 4] = !inc_here   ? clean :
                                        (cur >= 4'd9) ? 4'd0 : cur + 4'd1;
            assign dec_vec[4*gi +: 4] = !dec_here   ? clean :
                                        (cur == 4'd0) ? 4'd9 :
                                        (cur > 4'd9)  ? 4'd0 : cur - 4'd1;

            assign load_clean[4*gi +: 4] = (lv > 4'd9) ? 4'd0 : lv;
            assign bus.hex[7*gi +: 7]    = seg7(cur);
        end
    endgenerate

    assign all_nine  = &is_nine;
    assign all_zero  = &is_zero;
    assign step_edge = bus.step & ~step_d_reg;

    always_comb begin
        bcd_next = bcd_reg;
        ovf_next = 1'b0;
        if (bus.load) begin
            // Load wins outright; a coincident step edge is dropped.
            bcd_next = load_clean;
        end else if (step_edge && bus.en) begin
            if (bus.up) begin
                ovf_next = all_nine;
                // inc_vec already rolls all-9s over to all-0s.
                bcd_next = (all_nine && !WRAP) ? bcd_reg : inc_vec;
            end else begin
                ovf_next = all_zero;
                bcd_next = (all_zero && !WRAP) ? bcd_reg : dec_vec;
            end
        end
    end

    always_ff @(posedge clk or negedge Re_n) begin
        if (!Re_n) begin
            bcd_reg    <= '0;
            ovf_reg    <= 1'b0;
            // Treat step as already high so a held step at release does not count.
            step_d_reg <= 1'b1;
        end else begin
            bcd_reg    <= bcd_next;
            ovf_reg    <= ovf_next;
            step_d_reg <= bus.step;
        end
    end

    assign bus.bcd = bcd_reg;
    assign bus.ovf = ovf_reg;
    assign bus.tc  = bus.up ? all_nine : all_zero;

endmodule
